memch_multichannel_ctrl: RTL and testbench

Parametrised memory-channel controller that sequences NUM_CH channel memories through a convolution pass. It holds the channel memories and channel counter in clear until started, then tracks the active channel index. On each new-channel request it waits for the output routine to drain, advances the index, and reports completion or wrap-around. It sits between the top-level accelerator control and the channel-memory and counter datapath, and replaces the fixed three-channel controller.

---
 rtl/memch_pkg.sv | 17 +
 rtl/memch_ch_counter.sv | 47 ++++
 rtl/memch_multichannel_ctrl.sv | 142 ++++++++++++++
 tb/tb_memch_multichannel_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/memch_pkg.sv
// Shared types and helpers for the multichannel memory-channel controller.
package memch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RUN      = 3'd1,
    ST_WAIT_OUT = 3'd2,
    ST_NEWCH    = 3'd3,
    ST_DONE     = 3'd4
  } memch_state_e;

  // Index width that never collapses to zero bits.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/memch_ch_counter.sv
// Channel index register: enable, synchronous clear, last-index flag, optional wrap.
// Updates on the falling clock edge to match the controller it serves.
module memch_ch_counter
  import memch_pkg::*;
#(
  parameter  int unsigned NUM  = 3,
  parameter  bit          WRAP = 1'b0,
  localparam int unsigned W    = clog2_min1(NUM)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         is_last
);

  localparam logic [W-1:0] LAST = W'(NUM - 1);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      if (count_q == LAST) begin
        // Without wrap the index parks on the last channel.
        count_d = WRAP ? '0 : count_q;
      end else begin
        count_d = count_q + W'(1);
      end
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count   = count_q;
  assign is_last = (count_q == LAST);

endmodule

// File: rtl/memch_multichannel_ctrl.sv
// Sequences NUM_CH channel memories through a convolution pass; falling-edge clocked.
// Define MEMCH_AUTO_WRAP_EN for continuous streaming with a per-wrap Done pulse.
module memch_multichannel_ctrl
  import memch_pkg::*;
#(
  parameter  int unsigned NUM_CH    = 3,
  parameter  int unsigned TIMEOUT_W = 8,
  localparam int unsigned CH_W      = clog2_min1(NUM_CH)
) (
  input  logic              MEMCH_STATEMACHINE_Clk,
  input  logic              MEMCH_STATEMACHINE_Reset,
  input  logic              MEMCH_STATEMACHINE_Start,
  input  logic              MEMCH_STATEMACHINE_Abort,
  input  logic              MEMCH_STATEMACHINE_New_Channel_Flag,
  input  logic              MEMCH_STATEMACHINE_In_Output_Routine,
  output logic              MEMCH_STATEMACHINE_Counter_Ch_Clr,
  output logic [NUM_CH-1:0] MEMCH_STATEMACHINE_Chmem_Clr,
  output logic              MEMCH_STATEMACHINE_Counter_En,
  output logic [CH_W-1:0]   MEMCH_STATEMACHINE_Ch_Index,
  output logic              MEMCH_STATEMACHINE_Busy,
  output logic              MEMCH_STATEMACHINE_Done,
  output logic              MEMCH_STATEMACHINE_Timeout_Err
);

`ifdef MEMCH_AUTO_WRAP_EN
  localparam bit AUTO_WRAP = 1'b1;
`else
  localparam bit AUTO_WRAP = 1'b0;
`endif

  memch_state_e         state_q, state_d;
  logic [TIMEOUT_W-1:0] wd_q, wd_d, wd_inc;
  logic                 terr_q, terr_d;
  logic                 clr_rel_q, clr_rel_d;
  logic                 cen_q, cen_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 ch_clr, ch_en, ch_last;
  logic [CH_W-1:0]      ch_index;

  always_comb begin
    state_d = state_q;
    wd_d    = wd_q;
    terr_d  = terr_q;
    wd_inc  = wd_q + TIMEOUT_W'(1);
    case (state_q)
      ST_IDLE: begin
        if (!MEMCH_STATEMACHINE_Abort && MEMCH_STATEMACHINE_Start) begin
          state_d = ST_RUN;
          terr_d  = 1'b0;
        end
      end
      ST_RUN: begin
        if (MEMCH_STATEMACHINE_Abort) begin
          state_d = ST_IDLE;
        end else if (MEMCH_STATEMACHINE_New_Channel_Flag) begin
          state_d = ST_WAIT_OUT;
          wd_d    = '0;
        end
      end
      ST_WAIT_OUT: begin
        wd_d = wd_inc;
        // A drain completing on the same edge as the watchdog expiry wins.
        if (MEMCH_STATEMACHINE_Abort) begin
          state_d = ST_IDLE;
        end else if (!MEMCH_STATEMACHINE_In_Output_Routine) begin
          state_d = ST_NEWCH;
        end else if (wd_inc == '1) begin
          state_d = ST_IDLE;
          terr_d  = 1'b1;
        end
      end
      ST_NEWCH: begin
        if (MEMCH_STATEMACHINE_Abort) begin
          state_d = ST_IDLE;
        end else if (!ch_last || AUTO_WRAP) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (MEMCH_STATEMACHINE_Abort || !MEMCH_STATEMACHINE_Start) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registers mirror the state register.
  always_comb begin
    clr_rel_d = (state_d != ST_IDLE);
    cen_d     = (state_d == ST_NEWCH);
    busy_d    = (state_d == ST_RUN) || (state_d == ST_WAIT_OUT) || (state_d == ST_NEWCH);
    done_d    = AUTO_WRAP ? ((state_d == ST_NEWCH) && ch_last) : (state_d == ST_DONE);
  end

  assign ch_clr = (state_d == ST_IDLE);
  assign ch_en  = (state_q == ST_NEWCH);

  memch_ch_counter #(
    .NUM  (NUM_CH),
    .WRAP (AUTO_WRAP)
  ) u_ch_counter (
    .clk     (MEMCH_STATEMACHINE_Clk),
    .rst_n   (MEMCH_STATEMACHINE_Reset),
    .clr     (ch_clr),
    .en      (ch_en),
    .count   (ch_index),
    .is_last (ch_last)
  );

  always_ff @(negedge MEMCH_STATEMACHINE_Clk or negedge MEMCH_STATEMACHINE_Reset) begin
    if (!MEMCH_STATEMACHINE_Reset) begin
      state_q   <= ST_IDLE;
      wd_q      <= '0;
      terr_q    <= 1'b0;
      clr_rel_q <= 1'b0;
      cen_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wd_q      <= wd_d;
      terr_q    <= terr_d;
      clr_rel_q <= clr_rel_d;
      cen_q     <= cen_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign MEMCH_STATEMACHINE_Counter_Ch_Clr = clr_rel_q;
  assign MEMCH_STATEMACHINE_Chmem_Clr      = {NUM_CH{clr_rel_q}};
  assign MEMCH_STATEMACHINE_Counter_En     = cen_q;
  assign MEMCH_STATEMACHINE_Ch_Index       = ch_index;
  assign MEMCH_STATEMACHINE_Busy           = busy_q;
  assign MEMCH_STATEMACHINE_Done           = done_q;
  assign MEMCH_STATEMACHINE_Timeout_Err    = terr_q;

endmodule

// File: tb/tb_memch_multichannel_ctrl.sv
// Table-driven bench for memch_multichannel_ctrl with a scoreboard of expected outputs.
// Honours MEMCH_AUTO_WRAP_EN to exercise the streaming build.
module tb_memch_multichannel_ctrl;

  localparam int unsigned TW = 4;
`ifdef MEMCH_AUTO_WRAP_EN
  localparam int unsigned NCH  = 4;
  localparam bit          WRAP = 1'b1;
`else
  localparam int unsigned NCH  = 3;
  localparam bit          WRAP = 1'b0;
`endif
  localparam int unsigned CW = (NCH <= 2) ? 1 : $clog2(NCH);

  typedef enum logic [2:0] {S_I, S_R, S_W, S_N, S_D} st_t;

  typedef struct packed {
    logic           clr;
    logic [NCH-1:0] chmem;
    logic           cen;
    logic [CW-1:0]  idx;
    logic           busy;
    logic           done;
    logic           terr;
  } out_t;

  typedef struct {
    logic        start;
    logic        abort;
    logic        ncf;
    logic        ior;
    st_t         st;
    int unsigned idx;
    logic        terr;
  } vec_t;

  logic           clk, rst_n, start, abort, ncf, ior;
  logic           o_clr, o_cen, o_busy, o_done, o_terr;
  logic [NCH-1:0] o_chmem;
  logic [CW-1:0]  o_idx;
  out_t           act;
  logic           cen_prev;

  int   checks   = 0;
  int   failures = 0;
  out_t sb[$];
  vec_t tbl[$];

  memch_multichannel_ctrl #(
    .NUM_CH    (NCH),
    .TIMEOUT_W (TW)
  ) dut (
    .MEMCH_STATEMACHINE_Clk               (clk),
    .MEMCH_STATEMACHINE_Reset             (rst_n),
    .MEMCH_STATEMACHINE_Start             (start),
    .MEMCH_STATEMACHINE_Abort             (abort),
    .MEMCH_STATEMACHINE_New_Channel_Flag  (ncf),
    .MEMCH_STATEMACHINE_In_Output_Routine (ior),
    .MEMCH_STATEMACHINE_Counter_Ch_Clr    (o_clr),
    .MEMCH_STATEMACHINE_Chmem_Clr         (o_chmem),
    .MEMCH_STATEMACHINE_Counter_En        (o_cen),
    .MEMCH_STATEMACHINE_Ch_Index          (o_idx),
    .MEMCH_STATEMACHINE_Busy              (o_busy),
    .MEMCH_STATEMACHINE_Done              (o_done),
    .MEMCH_STATEMACHINE_Timeout_Err       (o_terr)
  );

  assign act = {o_clr, o_chmem, o_cen, o_idx, o_busy, o_done, o_terr};

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  // Expected outputs of each state, straight from the state table.
  function automatic out_t expect_of(st_t st, int unsigned idx, logic terr);
    out_t o;
    o.clr   = (st != S_I);
    o.chmem = {NCH{o.clr}};
    o.cen   = (st == S_N);
    o.idx   = CW'(idx);
    o.busy  = (st == S_R) || (st == S_W) || (st == S_N);
    o.done  = (st == S_D) || (WRAP && (st == S_N) && (idx == NCH - 1));
    o.terr  = terr;
    return o;
  endfunction

  function automatic void add(logic s, logic a, logic n, logic r, st_t st, int unsigned idx, logic terr);
    vec_t v;
    v.start = s; v.abort = a; v.ncf = n; v.ior = r;
    v.st = st; v.idx = idx; v.terr = terr;
    tbl.push_back(v);
  endfunction

  task automatic check_out(input string name);
    out_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL %s scoreboard empty, got=%h", name, act);
    end else begin
      e = sb.pop_front();
      if (act !== e) begin
        failures++;
        $display("FAIL %s got=%h exp=%h", name, act, e);
      end
    end
  endtask

  // Drive after the sampling (rising) edge, let the DUT step on the falling edge, compare on the next rising edge.
  task automatic apply(input logic s, input logic a, input logic n, input logic r,
                       input st_t st, input int unsigned idx, input logic terr, input string name);
    start = s; abort = a; ncf = n; ior = r;
    sb.push_back(expect_of(st, idx, terr));
    @(negedge clk);
    @(posedge clk);
    check_out(name);
  endtask

  // Counter_En must never be high on two consecutive cycles.
  always @(posedge clk) begin
    if (rst_n && o_cen) begin
      checks++;
      if (cen_prev) begin
        failures++;
        $display("FAIL cen_back_to_back got=1 exp=0");
      end
    end
    cen_prev <= o_cen;
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; ncf = 1'b0; ior = 1'b0; cen_prev = 1'b0;
    repeat (2) @(posedge clk);
    sb.push_back(expect_of(S_I, 0, 1'b0));
    check_out("reset");
    rst_n = 1'b1;

`ifdef MEMCH_AUTO_WRAP_EN
    add(1, 0, 0, 0, S_R, 0, 0);
    for (int k = 0; k < 5; k++) begin
      add(0, 0, 1, 0, S_W, k % NCH, 0);
      add(0, 0, 0, 0, S_N, k % NCH, 0);
      add(0, 0, 0, 0, S_R, (k + 1) % NCH, 0);
    end
    add(0, 1, 0, 0, S_I, 0, 0);
`else
    add(0, 0, 0, 0, S_I, 0, 0);
    add(1, 0, 1, 0, S_R, 0, 0);
    add(1, 0, 0, 0, S_R, 0, 0);
    add(1, 0, 1, 0, S_W, 0, 0);
    add(1, 0, 1, 0, S_N, 0, 0);
    add(1, 0, 1, 0, S_R, 1, 0);
    add(1, 0, 0, 0, S_R, 1, 0);
    add(1, 0, 1, 1, S_W, 1, 0);
    for (int k = 0; k < 4; k++) add(1, 0, 0, 1, S_W, 1, 0);
    add(1, 0, 0, 0, S_N, 1, 0);
    add(1, 0, 0, 0, S_R, 2, 0);
    add(1, 0, 1, 0, S_W, 2, 0);
    add(1, 0, 0, 0, S_N, 2, 0);
    add(1, 0, 0, 0, S_D, 2, 0);
    add(1, 0, 0, 0, S_D, 2, 0);
    add(0, 0, 0, 0, S_I, 0, 0);
`endif
    // Abort in WAIT_OUT at index 1, with Start also high.
    add(1, 0, 0, 0, S_R, 0, 0);
    add(0, 0, 1, 0, S_W, 0, 0);
    add(0, 0, 0, 0, S_N, 0, 0);
    add(0, 0, 0, 0, S_R, 1, 0);
    add(0, 0, 1, 1, S_W, 1, 0);
    add(1, 1, 0, 1, S_I, 0, 0);
    add(0, 0, 0, 0, S_I, 0, 0);
    // Watchdog: output routine stuck busy.
    add(1, 0, 0, 0, S_R, 0, 0);
    add(0, 0, 1, 1, S_W, 0, 0);
    for (int k = 0; k < 14; k++) add(0, 0, 0, 1, S_W, 0, 0);
    add(0, 0, 0, 1, S_I, 0, 1);
    add(0, 0, 0, 0, S_I, 0, 1);
    add(1, 0, 0, 0, S_R, 0, 0);
    add(0, 1, 0, 0, S_I, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].start, tbl[i].abort, tbl[i].ncf, tbl[i].ior,
            tbl[i].st, tbl[i].idx, tbl[i].terr, $sformatf("vec%0d", i));
    end

    // Asynchronous reset in the middle of NEWCH, checked before any clock edge.
    apply(1, 0, 0, 0, S_R, 0, 0, "ar_run");
    apply(0, 0, 1, 0, S_W, 0, 0, "ar_wait");
    apply(0, 0, 0, 0, S_N, 0, 0, "ar_newch");
    #2 rst_n = 1'b0;
    #1;
    sb.push_back(expect_of(S_I, 0, 1'b0));
    check_out("async_reset");
    @(posedge clk);
    rst_n = 1'b1;
    apply(0, 0, 0, 0, S_I, 0, 0, "post_reset_idle");
    apply(1, 0, 0, 0, S_R, 0, 0, "post_reset_start");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
